// File: rtl/inst_fetch_pkg.sv
// Shared CPU definitions used by the fetch stage: NOP encoding and fetch state type.
package inst_fetch_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch stage with zero-bubble redirect and stall freeze.
// Optional misaligned-redirect trap check is enabled by defining INST_MISALIGN_CHK_EN.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned IMEM_AW      = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_run,
  input  logic               stall,
  input  logic               jmp_condition,
  input  logic [31:0]        jmp_adr,
  output logic [IMEM_AW-1:0] imem_adr,
  output logic               imem_re,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        inst_id,
  output logic [31:0]        pc_id,
  output logic               inst_valid_id,
  output logic               misalign,
  output logic [31:0]        misalign_adr
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_if;
  logic [31:0]  fetch_adr;
  logic         mis_redirect;

  // Byte addresses are kept word aligned; low two target bits never reach the PC.
  assign fetch_adr = jmp_condition ? (jmp_adr & 32'hFFFF_FFFC) : pc_if;
  assign imem_adr  = fetch_adr[IMEM_AW+1:2];

`ifdef INST_MISALIGN_CHK_EN
  assign mis_redirect = jmp_condition & (jmp_adr[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign     <= 1'b0;
      misalign_adr <= '0;
    end else begin
      misalign <= mis_redirect;
      if (mis_redirect) misalign_adr <= jmp_adr;
    end
  end
`else
  assign mis_redirect = 1'b0;
  assign misalign     = 1'b0;
  assign misalign_adr = '0;
`endif

  always_comb begin
    state_d = state_q;
    if (mis_redirect) state_d = IDLE;
    else if (!stall)  state_d = cpu_run ? RUN : IDLE;
  end

  // Redirects override stall and halt; reset masks the enable so no read leaks out.
  assign imem_re = rst_n & ~mis_redirect & (jmp_condition | (cpu_run & ~stall));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_if         <= RESET_VECTOR;
      pc_id         <= RESET_VECTOR;
      inst_valid_id <= 1'b0;
    end else begin
      state_q <= state_d;
      if (imem_re) begin
        pc_id <= fetch_adr;
        pc_if <= fetch_adr + 32'd4;
      end
      if (!(stall && !jmp_condition)) inst_valid_id <= imem_re;
    end
  end

  assign inst_id = inst_valid_id ? imem_rdata : NOP;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch with a simple registered instruction memory.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_run;
  logic        stall;
  logic        jmp_condition;
  logic [31:0] jmp_adr;
  logic [11:0] imem_adr;
  logic        imem_re;
  logic [31:0] imem_rdata;
  logic [31:0] inst_id;
  logic [31:0] pc_id;
  logic        inst_valid_id;
  logic        misalign;
  logic [31:0] misalign_adr;

  int unsigned total = 0;
  int unsigned bad   = 0;

  inst_fetch #(.RESET_VECTOR(32'h0000_0000), .IMEM_AW(12)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_run       (cpu_run),
    .stall         (stall),
    .jmp_condition (jmp_condition),
    .jmp_adr       (jmp_adr),
    .imem_adr      (imem_adr),
    .imem_re       (imem_re),
    .imem_rdata    (imem_rdata),
    .inst_id       (inst_id),
    .pc_id         (pc_id),
    .inst_valid_id (inst_valid_id),
    .misalign      (misalign),
    .misalign_adr  (misalign_adr)
  );

  always #5 clk = ~clk;

  // Memory word at word address w reads as C0DE_0000 + w; output held while not enabled.
  always @(posedge clk) begin
    if (imem_re) imem_rdata <= 32'hC0DE_0000 | {20'h0, imem_adr};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    imem_rdata    = 32'h0;
    rst_n         = 1'b0;
    cpu_run       = 1'b0;
    stall         = 1'b0;
    jmp_condition = 1'b0;
    jmp_adr       = 32'h0;
    tick();
    tick();
    chk("rst_valid",  {31'h0, inst_valid_id}, 32'h0);
    chk("rst_inst",   inst_id, 32'h0000_0013);
    chk("rst_pc",     pc_id, 32'h0);
    chk("rst_re",     {31'h0, imem_re}, 32'h0);
    chk("rst_mis",    {31'h0, misalign}, 32'h0);
    chk("rst_misadr", misalign_adr, 32'h0);

    // Sequential fetch from the reset vector
    rst_n = 1'b1;
    cpu_run = 1'b1;
    #1;
    chk("seq_re0",  {31'h0, imem_re}, 32'h1);
    chk("seq_adr0", {20'h0, imem_adr}, 32'h0);
    tick();
    chk("seq_pc0",  pc_id, 32'h0);
    chk("seq_val0", {31'h0, inst_valid_id}, 32'h1);
    chk("seq_ins0", inst_id, 32'hC0DE_0000);
    chk("seq_adr1", {20'h0, imem_adr}, 32'h1);
    tick();
    chk("seq_pc4",  pc_id, 32'h4);
    chk("seq_ins1", inst_id, 32'hC0DE_0001);
    tick();
    chk("seq_pc8",  pc_id, 32'h8);
    chk("seq_ins2", inst_id, 32'hC0DE_0002);

    // Three-cycle stall at pc_id=8
    stall = 1'b1;
    #1;
    chk("stl_re", {31'h0, imem_re}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stl_pc",  pc_id, 32'h8);
      chk("stl_ins", inst_id, 32'hC0DE_0002);
      chk("stl_val", {31'h0, inst_valid_id}, 32'h1);
      chk("stl_re2", {31'h0, imem_re}, 32'h0);
    end
    stall = 1'b0;
    #1;
    chk("stl_adr3", {20'h0, imem_adr}, 32'h3);
    tick();
    chk("stl_pc12", pc_id, 32'hC);
    chk("stl_ins3", inst_id, 32'hC0DE_0003);

    // Plain redirect
    jmp_condition = 1'b1;
    jmp_adr = 32'h0000_0100;
    #1;
    chk("jmp_adr", {20'h0, imem_adr}, 32'h40);
    tick();
    jmp_condition = 1'b0;
    chk("jmp_pc",  pc_id, 32'h100);
    chk("jmp_ins", inst_id, 32'hC0DE_0040);
    tick();
    chk("jmp_pc4", pc_id, 32'h104);
    chk("jmp_ins4", inst_id, 32'hC0DE_0041);

    // Redirect wins over stall
    stall = 1'b1;
    jmp_condition = 1'b1;
    jmp_adr = 32'h0000_0200;
    #1;
    chk("jst_re", {31'h0, imem_re}, 32'h1);
    tick();
    jmp_condition = 1'b0;
    chk("jst_pc",  pc_id, 32'h200);
    chk("jst_ins", inst_id, 32'hC0DE_0080);
    tick();
    chk("jst_hold", pc_id, 32'h200);
    chk("jst_val",  {31'h0, inst_valid_id}, 32'h1);
    stall = 1'b0;
    tick();
    chk("jst_pc4", pc_id, 32'h204);

    // Halt then resume at held pc_if
    cpu_run = 1'b0;
    #1;
    chk("hlt_re", {31'h0, imem_re}, 32'h0);
    tick();
    chk("hlt_val", {31'h0, inst_valid_id}, 32'h0);
    chk("hlt_ins", inst_id, 32'h0000_0013);
    chk("hlt_pc",  pc_id, 32'h204);
    tick();
    chk("hlt_ins2", inst_id, 32'h0000_0013);
    cpu_run = 1'b1;
    #1;
    chk("res_adr", {20'h0, imem_adr}, 32'h82);
    tick();
    chk("res_pc",  pc_id, 32'h208);
    chk("res_ins", inst_id, 32'hC0DE_0082);

    // Redirect while idle performs exactly one fetch
    cpu_run = 1'b0;
    tick();
    jmp_condition = 1'b1;
    jmp_adr = 32'h0000_0300;
    tick();
    jmp_condition = 1'b0;
    chk("idj_pc",  pc_id, 32'h300);
    chk("idj_val", {31'h0, inst_valid_id}, 32'h1);
    chk("idj_ins", inst_id, 32'hC0DE_00C0);
    #1;
    chk("idj_re", {31'h0, imem_re}, 32'h0);
    tick();
    chk("idj_val2", {31'h0, inst_valid_id}, 32'h0);

    // PC wraps from FFFF_FFFC to 0
    cpu_run = 1'b1;
    jmp_condition = 1'b1;
    jmp_adr = 32'hFFFF_FFFC;
    tick();
    jmp_condition = 1'b0;
    chk("wrp_pc",  pc_id, 32'hFFFF_FFFC);
    chk("wrp_ins", inst_id, 32'hC0DE_0FFF);
    #1;
    chk("wrp_adr", {20'h0, imem_adr}, 32'h0);
    tick();
    chk("wrp_pc0", pc_id, 32'h0);

    // Misaligned redirect target
    jmp_condition = 1'b1;
    jmp_adr = 32'h0000_0102;
    #1;
`ifdef INST_MISALIGN_CHK_EN
    chk("mis_re", {31'h0, imem_re}, 32'h0);
    tick();
    jmp_condition = 1'b0;
    chk("mis_pulse", {31'h0, misalign}, 32'h1);
    chk("mis_adr",   misalign_adr, 32'h102);
    chk("mis_val",   {31'h0, inst_valid_id}, 32'h0);
    chk("mis_pc",    pc_id, 32'h0);
    tick();
    chk("mis_end",   {31'h0, misalign}, 32'h0);
    chk("mis_adrh",  misalign_adr, 32'h102);
    chk("mis_pc4",   pc_id, 32'h4);
`else
    chk("mis_re",  {31'h0, imem_re}, 32'h1);
    chk("mis_fadr", {20'h0, imem_adr}, 32'h40);
    tick();
    jmp_condition = 1'b0;
    chk("mis_pc",  pc_id, 32'h100);
    chk("mis_off", {31'h0, misalign}, 32'h0);
    chk("mis_adr", misalign_adr, 32'h0);
`endif

    // Asynchronous reset mid-fetch
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_val", {31'h0, inst_valid_id}, 32'h0);
    chk("arst_pc",  pc_id, 32'h0);
    chk("arst_ins", inst_id, 32'h0000_0013);
    chk("arst_re",  {31'h0, imem_re}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_pc0",  pc_id, 32'h0);
    chk("arst_ins0", inst_id, 32'hC0DE_0000);
    tick();
    chk("arst_pc4",  pc_id, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter IMEM_AW, 12, instruction-memory word-address width.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 cpu_run  in  1  1 = fetch enabled; 0 = fetch halted.
REQ-006 stall  in  1  load-use stall from decode; freezes fetch.
REQ-007 jmp_condition  in  1  taken jump/branch/trap redirect request.
REQ-008 jmp_adr  in  32  redirect target byte address.
REQ-009 imem_adr  out  IMEM_AW  instruction-memory word address.
REQ-010 imem_re  out  1  instruction-memory read enable.
REQ-011 imem_rdata  in  32  read data, valid one cycle after imem_adr/imem_re; memory holds output while imem_re=0.
REQ-012 inst_id  out  32  instruction presented to decoder.
REQ-013 pc_id  out  32  byte address of inst_id.
REQ-014 inst_valid_id  out  1  inst_id is a real fetched instruction.
REQ-015 misalign  out  1  one-cycle pulse, misaligned redirect (INST_MISALIGN_CHK_EN only).
REQ-016 misalign_adr  out  32  offending target, held until next misalign (INST_MISALIGN_CHK_EN only).

Function
REQ-017 States IDLE, RUN; IDLE -> RUN when cpu_run=1 and stall=0; RUN -> IDLE when cpu_run=0 and stall=0; stall=1 holds state.
REQ-018 Fetch address mux: imem_adr = jmp_condition ? jmp_adr[IMEM_AW+1:2] : pc_if[IMEM_AW+1:2].
REQ-019 imem_re = jmp_condition | (cpu_run & ~stall & state transitions into or stays in RUN).
REQ-020 Each cycle with imem_re=1: pc_id <= fetched address, pc_if <= fetched address + 4, 32-bit wrap from 32'hFFFF_FFFC to 0.
REQ-021 Zero-bubble redirect: target instruction appears on inst_id the cycle after jmp_condition; flushing of younger in-flight instructions is owned by downstream stages.
REQ-022 jmp_condition has priority over stall and over cpu_run=0; a redirect while IDLE performs one fetch and remains IDLE unless cpu_run=1.
REQ-023 stall=1 without jmp_condition: pc_if, pc_id, inst_valid_id, state frozen; imem_re=0, so inst_id stays stable.
REQ-024 inst_valid_id <= imem_re (registered); while inst_valid_id=0, inst_id = 32'h0000_0013 (NOP), else inst_id = imem_rdata.
REQ-025 pc_if bits [1:0] always 0; jmp_adr[1:0] ignored when the check is compiled out.

Reset
REQ-026 rst_n=0: state IDLE, pc_if=RESET_VECTOR, pc_id=RESET_VECTOR, inst_valid_id=0, inst_id=NOP, imem_re=0, misalign=0, misalign_adr=0.
REQ-027 Reset mid-fetch discards any in-flight read; first valid instruction after release is at RESET_VECTOR.

Configuration
REQ-028 Macro INST_MISALIGN_CHK_EN defined: redirect with jmp_adr[1:0]!=0 is not taken (imem_re=0 that cycle, pc_if unchanged), misalign pulses one cycle, misalign_adr <= jmp_adr, state -> IDLE.
REQ-029 Macro undefined: misalign tied 0, misalign_adr tied 0, no check logic; all redirects taken.

Structure
REQ-030 Shared CPU package holds NOP constant 32'h0000_0013 and the fetch state encoding.
REQ-031 Single flat module; no sub-module; memory is external.

Verification
REQ-032 Reset release, cpu_run=1 -> imem_adr 0,1,2...; inst_valid_id rises one cycle later with pc_id 0,4,8.
REQ-033 stall high 3 cycles at pc_id=8 -> inst_id, pc_id=8 stable, imem_re=0; resumes with pc_id=12.
REQ-034 jmp_condition, jmp_adr=32'h0000_0100 -> next cycle pc_id=0x100, then 0x104.
REQ-035 jmp_condition with stall=1 -> redirect taken, pc_id=target next cycle.
REQ-036 cpu_run=0 -> state IDLE, inst_valid_id=0, inst_id=NOP; cpu_run=1 resumes at held pc_if.
REQ-037 INST_MISALIGN_CHK_EN, jmp_adr=32'h0000_0102 -> misalign 1 cycle, misalign_adr=0x102, no fetch, IDLE.
